spi_ram_ctrl: RTL and testbench
===============================

# spi_ram_ctrl

Command sequencer between the SPI slave's parallel side and a single-port synchronous RAM. Decodes each 10-bit `rx_data` word into address-load, write, or read operations. Drives the RAM strobes and returns read data to the SPI slave through `tx_data`/`tx_valid`. Sits between the SPI slave and the memory macro in the SPI subsystem.

## Interface
- `ADDR_SIZE`, default 8: RAM address width, 1..8. Memory depth is 2**ADDR_SIZE.

Ports:
- `clk` in 1: sole clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rx_data` in 10: command word from SPI slave; [9:8] is the opcode, [7:0] is the payload.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid while it is high.
- `tx_data` out 8: read data to SPI slave.
- `tx_valid` out 1: one-cycle strobe qualifying `tx_data`.
- `mem_en` out 1: RAM access enable.
- `mem_we` out 1: RAM write enable; meaningful only with `mem_en`.
- `mem_addr` out ADDR_SIZE: RAM address.
- `mem_wdata` out 8: RAM write data.
- `mem_rdata` in 8: RAM read data, valid one cycle after a read strobe.
- `busy` out 1: high when state is not IDLE.
- `cmd_err` out 1: one-cycle pulse on a rejected command.

## Operation
- Internal registers: `wr_addr`, `rd_addr` (ADDR_SIZE each), and `rd_addr_vld` (1 bit).
- Address payload is `rx_data[ADDR_SIZE-1:0]`; higher payload bits are ignored.
- Opcode 00, write-address load: `wr_addr` ← payload. No RAM access.
- Opcode 01, write data: one write strobe. `mem_en`=1, `mem_we`=1, `mem_addr`=`wr_addr`, `mem_wdata`=payload.
- Opcode 10, read-address load: `rd_addr` ← payload; `rd_addr_vld` ← 1.
- Opcode 11, read data: payload is ignored (dummy).
  - If `rd_addr_vld`=0: reject. Pulse `cmd_err`; no RAM access; no `tx_valid`.
  - Otherwise run the read sequence.
- States: IDLE, RD_REQ, RD_WAIT.
  - IDLE + accepted opcode 11 → RD_REQ.
  - RD_REQ → RD_WAIT, unconditionally.
  - RD_WAIT → IDLE, capturing `mem_rdata`.
  - Opcodes 00, 01 and 10 complete from IDLE in one cycle and stay in IDLE.
- `rx_valid` while `busy`=1: the command is dropped, `cmd_err` pulses, and no register changes.
- `tx_data` holds its last read value until the next completed read.
- `mem_addr` and `mem_wdata` hold their last values when `mem_en`=0. `mem_en` and `mem_we` are never high outside an access cycle.
- `rst` has priority over everything, including a same-cycle `rx_valid`.
- Reset values, all 0: `tx_data`, `tx_valid`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `cmd_err`, `wr_addr`, `rd_addr`, `rd_addr_vld`. State resets to IDLE.
- Reset mid-read (RD_REQ or RD_WAIT): the read is abandoned; no `tx_valid` is produced after release.

## Timing
- All outputs are registered. Edge E is the edge that samples `rx_valid`=1.
- Address loads: the register is updated at E.
- Write: `mem_en`/`mem_we`/`mem_addr`/`mem_wdata` are high/valid for exactly the one cycle following E.
- Read:
  - `mem_en`=1 and `mem_we`=0 with `mem_addr`=`rd_addr` during the cycle after E (state RD_REQ).
  - The RAM samples at E+1; `mem_rdata` is valid during cycle E+2 (state RD_WAIT).
  - It is captured at E+2; `tx_data` is valid and `tx_valid`=1 for the one cycle after E+2.
  - Read latency: `rx_valid` to `tx_valid` is 3 clocks.
- `busy` is high for the two cycles after E on a read.
- A new command is accepted in the same cycle `tx_valid` is high.
- `cmd_err` is high for the single cycle after the rejecting edge.

## Configuration
- `SPI_RAM_AUTOINC_EN` defined:
  - After each executed write, `wr_addr` ← `wr_addr`+1 modulo 2**ADDR_SIZE, updated at E.
  - After each completed read, `rd_addr` ← `rd_addr`+1 modulo 2**ADDR_SIZE, updated at the capture edge.
  - Wrap is from all-ones to 0.
- `SPI_RAM_AUTOINC_EN` undefined: `wr_addr`/`rd_addr` change only on opcode 00/10 loads.

## Test plan
- Reset: hold `rst`=1 with random `rx_data`/`rx_valid` → all outputs 0, `busy`=0. With `rst` and `rx_valid` in the same cycle → no effect.
- Write: `rx_data`=0x02A, then 0x15C (`rx_valid` pulses) → one cycle after the second pulse: `mem_en`=1, `mem_we`=1, `mem_addr`=0x2A, `mem_wdata`=0x5C, then strobes low.
- Read: RAM model preloaded with 0x5C at 0x2A; send 0x22A, then 0x300 → `mem_en`=1/`mem_we`=0 at 0x2A one cycle after E; `tx_data`=0x5C with a single `tx_valid` pulse 3 cycles after E.
- Rejects:
  - After reset, send 0x300 → `cmd_err` pulse; `mem_en` and `tx_valid` stay 0.
  - Pulse `rx_valid` (0x15C) during RD_WAIT → `cmd_err` pulse, no write strobe; the read still returns its data.
- Reset mid-read: assert `rst` for one cycle in RD_WAIT → no `tx_valid` afterwards; `busy`=0; `tx_data`=0.
- Auto-increment: send 0x0FF, then 0x111 and 0x122 →
  - with `SPI_RAM_AUTOINC_EN`: write addresses 0xFF then 0x00;
  - without it: both writes at 0xFF.

Source files
------------

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: decodes 10-bit SPI command words into RAM address loads,
// single-beat writes and three-clock reads. Read data returns on tx_data/tx_valid.
// Optional build macro: SPI_RAM_AUTOINC_EN (post-access address auto-increment).
module spi_ram_ctrl #(
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 cmd_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [ADDR_SIZE-1:0] wr_addr, wr_addr_nx;
  logic [ADDR_SIZE-1:0] rd_addr, rd_addr_nx;
  logic                 rd_addr_vld, rd_addr_vld_nx;
  logic [7:0]           tx_data_nx;
  logic                 tx_valid_nx;
  logic                 mem_en_nx;
  logic                 mem_we_nx;
  logic [ADDR_SIZE-1:0] mem_addr_nx;
  logic [7:0]           mem_wdata_nx;
  logic                 busy_nx;
  logic                 cmd_err_nx;

  logic [1:0]           opcode;
  logic [ADDR_SIZE-1:0] payload_addr;

  assign opcode       = rx_data[9:8];
  assign payload_addr = rx_data[ADDR_SIZE-1:0];

  // Next-state and next-output decode; every output is registered below, so
  // the values computed here appear on the ports one cycle after the deciding edge.
  always_comb begin
    state_nx       = state;
    wr_addr_nx     = wr_addr;
    rd_addr_nx     = rd_addr;
    rd_addr_vld_nx = rd_addr_vld;
    tx_data_nx     = tx_data;
    tx_valid_nx    = 1'b0;
    mem_en_nx      = 1'b0;
    mem_we_nx      = 1'b0;
    mem_addr_nx    = mem_addr;
    mem_wdata_nx   = mem_wdata;
    cmd_err_nx     = 1'b0;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (opcode)
            2'b00: wr_addr_nx = payload_addr;
            2'b01: begin
              mem_en_nx    = 1'b1;
              mem_we_nx    = 1'b1;
              mem_addr_nx  = wr_addr;
              mem_wdata_nx = rx_data[7:0];
`ifdef SPI_RAM_AUTOINC_EN
              wr_addr_nx   = wr_addr + ADDR_SIZE'(1);
`endif
            end
            2'b10: begin
              rd_addr_nx     = payload_addr;
              rd_addr_vld_nx = 1'b1;
            end
            default: begin
              if (!rd_addr_vld) begin
                cmd_err_nx = 1'b1;
              end else begin
                state_nx    = RD_REQ;
                mem_en_nx   = 1'b1;
                mem_addr_nx = rd_addr;
              end
            end
          endcase
        end
      end
      RD_REQ: begin
        state_nx = RD_WAIT;
        if (rx_valid) cmd_err_nx = 1'b1;
      end
      RD_WAIT: begin
        state_nx    = IDLE;
        tx_data_nx  = mem_rdata;
        tx_valid_nx = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
        rd_addr_nx  = rd_addr + ADDR_SIZE'(1);
`endif
        if (rx_valid) cmd_err_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    // busy registered from the next state so it tracks state without a comb output path
    busy_nx = (state_nx != IDLE);
  end

  // State and output registers; synchronous reset overrides any same-cycle command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_addr     <= '0;
      rd_addr     <= '0;
      rd_addr_vld <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      wr_addr     <= wr_addr_nx;
      rd_addr     <= rd_addr_nx;
      rd_addr_vld <= rd_addr_vld_nx;
      tx_data     <= tx_data_nx;
      tx_valid    <= tx_valid_nx;
      mem_en      <= mem_en_nx;
      mem_we      <= mem_we_nx;
      mem_addr    <= mem_addr_nx;
      mem_wdata   <= mem_wdata_nx;
      busy        <= busy_nx;
      cmd_err     <= cmd_err_nx;
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: table of commands with expected strobes, a RAM model,
// and write/read scoreboards popped by a negedge monitor. Honours SPI_RAM_AUTOINC_EN.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       cmd_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  logic [7:0]  ram [256];

  typedef struct {
    logic [9:0] cmd;
    logic       err;
    logic       wr;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       rd;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl [16];

  spi_ram_ctrl #(.ADDR_SIZE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model: read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe and tx_valid must match a queued expectation.
  always @(negedge clk) begin
    if (mem_en && mem_we) begin
      if (wq.size() == 0) chk("unexpected write strobe", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      else chk("write addr/data", {mem_addr, mem_wdata}, wq.pop_front());
    end
    if (tx_valid) begin
      if (rq.size() == 0) chk("unexpected tx_valid", tx_data, 32'hFFFF_FFFF);
      else chk("tx_data", tx_data, rq.pop_front());
    end
  end

  task automatic send(input logic [9:0] cmd);
    @(negedge clk);
    rx_data  = cmd;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Expected write addresses differ with auto-increment; everything else is common.
`ifdef SPI_RAM_AUTOINC_EN
    tbl[7]  = '{10'h1C3, 1'b0, 1'b1, 8'h11, 8'hC3, 1'b0, 8'h00};
    tbl[9]  = '{10'h3FF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA5};
    tbl[13] = '{10'h122, 1'b0, 1'b1, 8'h00, 8'h22, 1'b0, 8'h00};
    tbl[15] = '{10'h300, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11};
`else
    tbl[7]  = '{10'h1C3, 1'b0, 1'b1, 8'h10, 8'hC3, 1'b0, 8'h00};
    tbl[9]  = '{10'h3FF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hC3};
    tbl[13] = '{10'h122, 1'b0, 1'b1, 8'hFF, 8'h22, 1'b0, 8'h00};
    tbl[15] = '{10'h300, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h22};
`endif
    tbl[0]  = '{10'h300, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{10'h02A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[2]  = '{10'h15C, 1'b0, 1'b1, 8'h2A, 8'h5C, 1'b0, 8'h00};
    tbl[3]  = '{10'h22A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[4]  = '{10'h300, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h5C};
    tbl[5]  = '{10'h010, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[6]  = '{10'h1A5, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00};
    tbl[8]  = '{10'h210, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[10] = '{10'h300, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hC3};
    tbl[11] = '{10'h0FF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[12] = '{10'h111, 1'b0, 1'b1, 8'hFF, 8'h11, 1'b0, 8'h00};
    tbl[14] = '{10'h2FF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};

    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    mem_rdata = 8'h00;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 10'h000;

    // Reset held with random command traffic: all outputs stay zero.
    repeat (6) begin
      @(negedge clk);
      chk("reset outputs", {tx_data, tx_valid, mem_en, mem_we, mem_addr, mem_wdata, busy, cmd_err}, 32'h0);
      rx_data  = 10'($urandom);
      rx_valid = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven command sequence.
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) wq.push_back({tbl[i].waddr, tbl[i].wdata});
      if (tbl[i].rd) rq.push_back(tbl[i].rdata);
      send(tbl[i].cmd);
      chk($sformatf("vec%0d cmd_err", i), cmd_err, tbl[i].err);
      chk($sformatf("vec%0d mem_en", i), mem_en, tbl[i].wr | tbl[i].rd);
      chk($sformatf("vec%0d mem_we", i), mem_we, tbl[i].wr);
      repeat (3) @(negedge clk);
    end

    // Read timing, cycle by cycle.
    send(10'h22A);
    repeat (2) @(negedge clk);
    rq.push_back(8'h5C);
    send(10'h300);
    chk("rd req strobe", {mem_en, mem_we, busy, tx_valid}, 4'b1010);
    chk("rd req addr", mem_addr, 8'h2A);
    @(negedge clk);
    chk("rd wait", {mem_en, busy, tx_valid}, 3'b010);
    @(negedge clk);
    chk("rd done", {busy, tx_valid}, 2'b01);
    @(negedge clk);
    chk("rd after tx_valid", tx_valid, 1'b0);
    chk("tx_data hold", tx_data, 8'h5C);
    repeat (2) @(negedge clk);

    // Command during RD_WAIT is rejected; read still completes.
    send(10'h22A);
    repeat (2) @(negedge clk);
    rq.push_back(8'h5C);
    send(10'h300);
    @(negedge clk);
    rx_data  = 10'h15C;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("busy reject cmd_err", cmd_err, 1'b1);
    chk("busy reject tx_valid", tx_valid, 1'b1);
    chk("busy reject no strobe", mem_en, 1'b0);
    @(negedge clk);
    chk("cmd_err single pulse", cmd_err, 1'b0);
    repeat (2) @(negedge clk);

    // Reset during RD_WAIT abandons the read.
    send(10'h22A);
    repeat (2) @(negedge clk);
    send(10'h300);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-read reset outputs", {tx_valid, busy, mem_en}, 3'b000);
    chk("mid-read reset tx_data", tx_data, 8'h00);
    repeat (4) begin
      @(negedge clk);
      chk("no tx_valid after reset", tx_valid, 1'b0);
    end
    send(10'h300);
    chk("read after reset rejected", {cmd_err, mem_en}, 2'b10);
    repeat (2) @(negedge clk);

    // Reset wins over a same-cycle address load.
    rst      = 1'b1;
    rx_data  = 10'h033;
    rx_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    chk("rst+rx_valid outputs", {mem_en, cmd_err, busy}, 3'b000);
    wq.push_back({8'h00, 8'hA5});
    send(10'h1A5);
    chk("write after rst+load", {mem_en, mem_we}, 2'b11);
    repeat (3) @(negedge clk);

    chk("write queue drained", wq.size(), 0);
    chk("read queue drained", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
